// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID register layout used by the fetch
// front end and the hazard logic.
package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: flags an IF/ID instruction whose source registers
// are written by a load currently sitting in ID/EX.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  ifid_valid,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    output logic                  hazard
);

    // Both source fields are compared regardless of format; a false match only
    // costs one bubble, never correctness.
    assign hazard = idex_memread & (idex_rd != '0) & ifid_valid &
                    ((idex_rd == rs1) | (idex_rd == rs2));

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, IF/ID pipeline register, load-use stall,
// ID-resolved branch redirect/flush and saturating stall/flush event counters.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000,
    parameter int              CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XLEN-1:0]       instr_i,
    input  logic                  mem_stall_i,
    input  logic                  branch_taken_i,
    input  logic [XLEN-1:0]       branch_target_i,
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    output logic [XLEN-1:0]       pc_o,
    output logic [XLEN-1:0]       ifid_pc_o,
    output logic [XLEN-1:0]       ifid_instr_o,
    output logic                  ifid_valid_o,
    output logic                  noop_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic [XLEN-1:0]  pc_p0;
    ifid_t            ifid_p1;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             hazard;
    logic             branch_eff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    hazard_detect u_hazard_detect (
        .rs1          (ifid_p1.instr[RS1_LSB +: REG_ADDR_W]),
        .rs2          (ifid_p1.instr[RS2_LSB +: REG_ADDR_W]),
        .ifid_valid   (ifid_p1.valid),
        .idex_memread (idex_memread_i),
        .idex_rd      (idex_rd_i),
        .hazard       (hazard)
    );

    // A branch whose operands are still being loaded must wait for the stall.
    assign branch_eff = branch_taken_i & ifid_p1.valid & ~hazard;
    assign noop_o     = hazard & ~mem_stall_i;
    assign stall_o    = hazard | mem_stall_i;

    // IF -> ID boundary: PC, IF/ID register and event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_p0       <= RESET_PC;
            ifid_p1     <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!mem_stall_i) begin
            if (hazard) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end else if (branch_eff) begin
                pc_p0       <= branch_target_i;
                ifid_p1     <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end else begin
                pc_p0       <= pc_p0 + PC_STEP;
                ifid_p1     <= '{pc: pc_p0, instr: instr_i, valid: 1'b1};
            end
        end
    end

    assign pc_o         = pc_p0;
    assign ifid_pc_o    = ifid_p1.pc;
    assign ifid_instr_o = ifid_p1.instr;
    assign ifid_valid_o = ifid_p1.valid;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus randomized traffic against a
// behavioural model of the fetch front end.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        mem_stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rd_i;

    logic [31:0] pc_o, ifid_pc_o, ifid_instr_o;
    logic        ifid_valid_o, noop_o, stall_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] pc4, ifid_pc4, ifid_instr4;
    logic        ifid_valid4, noop4, stall4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit [31:0] m_pc, m_ifid_pc, m_ifid_instr;
    bit        m_valid;
    int        m_stall_cnt, m_flush_cnt, m_stall_cnt4;

    if_id_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .mem_stall_i(mem_stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
        .pc_o(pc_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o), .noop_o(noop_o), .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    if_id_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .mem_stall_i(mem_stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
        .pc_o(pc4), .ifid_pc_o(ifid_pc4), .ifid_instr_o(ifid_instr4),
        .ifid_valid_o(ifid_valid4), .noop_o(noop4), .stall_o(stall4),
        .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit m_hazard();
        int rs1, rs2;
        rs1 = (m_ifid_instr / 32768) % 32;
        rs2 = (m_ifid_instr / 1048576) % 32;
        return idex_memread_i && (idex_rd_i != 0) && m_valid &&
               (idex_rd_i == rs1 || idex_rd_i == rs2);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
        m_stall_cnt = 0; m_flush_cnt = 0; m_stall_cnt4 = 0;
    endtask

    task automatic model_edge();
        if (mem_stall_i) begin
        end else if (m_hazard()) begin
            if (m_stall_cnt < 65535) m_stall_cnt++;
            if (m_stall_cnt4 < 15) m_stall_cnt4++;
        end else if (branch_taken_i && m_valid) begin
            m_pc = branch_target_i;
            m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
            if (m_flush_cnt < 65535) m_flush_cnt++;
        end else begin
            m_ifid_pc = m_pc; m_ifid_instr = instr_i; m_valid = 1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    // advance one clock; returns 1 time unit after the rising edge
    task automatic tick();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_stall_i = 0; branch_taken_i = 0; branch_target_i = 0;
        idex_memread_i = 0; idex_rd_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #2;
        model_reset();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        instr_i = 32'h0050_0093;
        rst_i = 1'b1;
        #1;
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc_o); end
        checks++; if (ifid_pc_o !== 32'h0) begin failures++; $display("FAIL rst_ifid_pc got=%h exp=0", ifid_pc_o); end
        checks++; if (ifid_instr_o !== 32'h0) begin failures++; $display("FAIL rst_ifid_instr got=%h exp=0", ifid_instr_o); end
        checks++; if (ifid_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ifid_valid_o); end
        checks++; if ({noop_o, stall_o} !== 2'b00) begin failures++; $display("FAIL rst_noop_stall got=%b exp=00", {noop_o, stall_o}); end
        checks++; if ({stall_cnt_o, flush_cnt_o} !== 32'h0) begin failures++; $display("FAIL rst_cnts got=%h exp=0", {stall_cnt_o, flush_cnt_o}); end
        mem_stall_i = 1'b1;
        #1;
        checks++; if ({noop_o, stall_o} !== 2'b01) begin failures++; $display("FAIL rst_memstall got=%b exp=01", {noop_o, stall_o}); end
        mem_stall_i = 1'b0;
        do_reset();
    endtask

    task automatic test_fetch();
        do_reset();
        instr_i = 32'h0050_0093;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (pc_o !== 32'(4 * k)) begin failures++; $display("FAIL fetch_pc got=%h exp=%h", pc_o, 4 * k); end
            checks++; if (ifid_pc_o !== 32'(4 * (k - 1)) || ifid_valid_o !== 1'b1 || ifid_instr_o !== 32'h0050_0093) begin
                failures++; $display("FAIL fetch_ifid got=%h/%b/%h exp=%h/1/00500093", ifid_pc_o, ifid_valid_o, ifid_instr_o, 4 * (k - 1));
            end
        end
        rst_i = 1'b1;
        #1;
        checks++; if (pc_o !== 32'h0 || ifid_pc_o !== 32'h0 || ifid_instr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin
            failures++; $display("FAIL midrun_rst got=%h/%h/%h/%b exp=0/0/0/0", pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o);
        end
        #1;
        model_reset();
        rst_i = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        instr_i = 32'h0020_8133;
        tick();
        idex_memread_i = 1; idex_rd_i = 5'd2;
        #1;
        checks++; if ({noop_o, stall_o} !== 2'b11) begin failures++; $display("FAIL lu_noop_stall got=%b exp=11", {noop_o, stall_o}); end
        tick();
        checks++; if (pc_o !== 32'h4 || ifid_instr_o !== 32'h0020_8133 || ifid_pc_o !== 32'h0) begin
            failures++; $display("FAIL lu_hold got=%h/%h/%h exp=4/00208133/0", pc_o, ifid_instr_o, ifid_pc_o);
        end
        checks++; if (stall_cnt_o !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt_o); end
        idex_rd_i = 5'd0;
        #1;
        checks++; if ({noop_o, stall_o} !== 2'b00) begin failures++; $display("FAIL lu_rd0 got=%b exp=00", {noop_o, stall_o}); end
        tick();
        checks++; if (pc_o !== 32'h8 || stall_cnt_o !== 16'd1) begin failures++; $display("FAIL lu_rd0_adv got=%h/%0d exp=8/1", pc_o, stall_cnt_o); end
        idle_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        instr_i = 32'h0050_0093;
        tick();
        branch_taken_i = 1; branch_target_i = 32'h40;
        tick();
        checks++; if (pc_o !== 32'h40 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc_o !== 32'h0) begin
            failures++; $display("FAIL br_redirect got=%h/%b/%h/%h exp=40/0/0/0", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_o);
        end
        checks++; if (flush_cnt_o !== 16'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt_o); end
        branch_taken_i = 0; instr_i = 32'h1234_5678;
        tick();
        checks++; if (ifid_pc_o !== 32'h40 || ifid_instr_o !== 32'h1234_5678 || pc_o !== 32'h44) begin
            failures++; $display("FAIL br_target_fetch got=%h/%h/%h exp=40/12345678/44", ifid_pc_o, ifid_instr_o, pc_o);
        end
        idle_inputs();
    endtask

    task automatic test_hazard_branch();
        do_reset();
        instr_i = 32'h0020_8133;
        tick();
        idex_memread_i = 1; idex_rd_i = 5'd1; branch_taken_i = 1; branch_target_i = 32'h80;
        tick();
        checks++; if (pc_o !== 32'h4 || flush_cnt_o !== 16'd0 || stall_cnt_o !== 16'd1 || ifid_valid_o !== 1'b1) begin
            failures++; $display("FAIL hb_stall_wins got=%h/%0d/%0d/%b exp=4/0/1/1", pc_o, flush_cnt_o, stall_cnt_o, ifid_valid_o);
        end
        idex_memread_i = 0;
        tick();
        checks++; if (pc_o !== 32'h80 || flush_cnt_o !== 16'd1 || ifid_valid_o !== 1'b0) begin
            failures++; $display("FAIL hb_late_redirect got=%h/%0d/%b exp=80/1/0", pc_o, flush_cnt_o, ifid_valid_o);
        end
        idle_inputs();
    endtask

    task automatic test_mem_stall();
        do_reset();
        instr_i = 32'h0020_8133;
        tick();
        idex_memread_i = 1; idex_rd_i = 5'd2; branch_taken_i = 1; branch_target_i = 32'h200;
        mem_stall_i = 1; instr_i = 32'hdead_beef;
        #1;
        checks++; if ({noop_o, stall_o} !== 2'b01) begin failures++; $display("FAIL ms_noop_stall got=%b exp=01", {noop_o, stall_o}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (pc_o !== 32'h4 || ifid_instr_o !== 32'h0020_8133 || ifid_valid_o !== 1'b1 ||
                          stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
                failures++; $display("FAIL ms_frozen got=%h/%h/%b/%0d/%0d exp=4/00208133/1/0/0",
                                     pc_o, ifid_instr_o, ifid_valid_o, stall_cnt_o, flush_cnt_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        instr_i = 32'h0050_0093;
        tick();
        branch_taken_i = 1; branch_target_i = 32'hFFFF_FFFC;
        tick();
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=fffffffc", pc_o); end
        branch_taken_i = 0;
        tick();
        checks++; if (pc_o !== 32'h0 || ifid_pc_o !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap got=%h/%h exp=0/fffffffc", pc_o, ifid_pc_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        instr_i = 32'h0020_8133;
        tick();
        idex_memread_i = 1; idex_rd_i = 5'd2;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (stall_cnt4 !== 4'd15 || stall_cnt4 !== 4'(m_stall_cnt4)) begin
            failures++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cnt4);
        end
        checks++; if (stall_cnt_o !== 16'd20) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_cnt_o); end
        checks++; if (pc4 !== 32'h4) begin failures++; $display("FAIL sat_pc4 got=%h exp=4", pc4); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit [31:0] ins;
        bit exp_hz;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            ins = $urandom();
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            instr_i         = ins;
            idex_memread_i  = ($urandom_range(0, 1) == 1);
            idex_rd_i       = 5'($urandom_range(0, 3));
            branch_taken_i  = ($urandom_range(0, 9) < 3);
            branch_target_i = $urandom();
            mem_stall_i     = ($urandom_range(0, 9) == 0);
            #1;
            exp_hz = m_hazard();
            checks++; if (noop_o !== (exp_hz && !mem_stall_i) || stall_o !== (exp_hz || mem_stall_i)) begin
                failures++; $display("FAIL rnd_ctrl n=%0d got=%b%b exp=%b%b", n, noop_o, stall_o,
                                     exp_hz && !mem_stall_i, exp_hz || mem_stall_i);
            end
            tick();
            checks++; if (pc_o !== m_pc || ifid_pc_o !== m_ifid_pc || ifid_instr_o !== m_ifid_instr || ifid_valid_o !== m_valid) begin
                failures++; $display("FAIL rnd_state n=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", n, pc_o, ifid_pc_o,
                                     ifid_instr_o, ifid_valid_o, m_pc, m_ifid_pc, m_ifid_instr, m_valid);
            end
            checks++; if (stall_cnt_o !== 16'(m_stall_cnt) || flush_cnt_o !== 16'(m_flush_cnt) || stall_cnt4 !== 4'(m_stall_cnt4)) begin
                failures++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, stall_cnt_o,
                                     flush_cnt_o, stall_cnt4, m_stall_cnt, m_flush_cnt, m_stall_cnt4);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_i = 1'b1;
        instr_i = 32'h0;
        idle_inputs();
        model_reset();
        test_reset();
        test_fetch();
        test_load_use();
        test_branch();
        test_hazard_branch();
        test_mem_stall();
        test_wrap();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
